// File: rtl/dist_ram_arb_pkg.sv
// Shared types and default widths for the dist_ram two-port arbiter.
package dist_ram_arb_pkg;
    localparam int DEF_ADDR_W = 10;
    localparam int DEF_DATA_W = 32;

    typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} arb_state_t;

    typedef logic arb_port_t;
endpackage

// File: rtl/dist_ram.sv
// Single-port distributed RAM: synchronous write, combinational read.
module dist_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              write_enable,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_write,
    output logic [DATA_W-1:0] data_out
);
    logic [DATA_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clk) begin
        if (write_enable)
            mem[addr] <= data_write;
    end

    assign data_out = mem[addr];
endmodule

// File: rtl/dist_ram_arb_pick.sv
// Combinational grant for two requesters. Round-robin pointer exists only
// when DIST_RAM_ARB_RR_EN is defined; otherwise port 0 has fixed priority.
module dist_ram_arb_pick
    import dist_ram_arb_pkg::*;
(
`ifdef DIST_RAM_ARB_RR_EN
    input  logic       clk,
    input  logic       rst,
    input  logic       adv,
`endif
    input  logic [1:0] valid,
    output logic [1:0] grant
);

`ifdef DIST_RAM_ARB_RR_EN
    arb_port_t ptr;

    // Pointer moves to the port that did not just win.
    always_ff @(posedge clk) begin
        if (rst)
            ptr <= 1'b0;
        else if (adv)
            ptr <= grant[0];
    end

    assign grant[0] = valid[0] & (~valid[1] | (ptr == 1'b0));
    assign grant[1] = valid[1] & (~valid[0] | (ptr == 1'b1));
`else
    assign grant[0] = valid[0];
    assign grant[1] = valid[1] & ~valid[0];
`endif

endmodule

// File: rtl/dist_ram_arbiter.sv
// Serialises port 0 (core) and port 1 (loader) onto one dist_ram port.
// Define DIST_RAM_ARB_RR_EN for round-robin; default is fixed priority to port 0.
module dist_ram_arbiter
    import dist_ram_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              p0_req_valid,
    output logic              p0_req_ready,
    input  logic              p0_req_we,
    input  logic [ADDR_W-1:0] p0_req_addr,
    input  logic [DATA_W-1:0] p0_req_wdata,
    output logic              p0_resp_valid,
    output logic [DATA_W-1:0] p0_resp_rdata,
    input  logic              p1_req_valid,
    output logic              p1_req_ready,
    input  logic              p1_req_we,
    input  logic [ADDR_W-1:0] p1_req_addr,
    input  logic [DATA_W-1:0] p1_req_wdata,
    output logic              p1_resp_valid,
    output logic [DATA_W-1:0] p1_resp_rdata,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata
);
    arb_state_t        state, state_nxt;
    logic [1:0]        grant;
    logic              accept;
    arb_port_t         acc_port, resp_port;
    logic              resp_vld;
    logic [DATA_W-1:0] resp_data;

    dist_ram_arb_pick u_pick (
`ifdef DIST_RAM_ARB_RR_EN
        .clk   (clk),
        .rst   (rst),
        .adv   (accept),
`endif
        .valid ({p1_req_valid, p0_req_valid}),
        .grant (grant)
    );

    always_comb begin
        state_nxt    = state;
        p0_req_ready = 1'b0;
        p1_req_ready = 1'b0;
        accept       = 1'b0;
        case (state)
            IDLE: begin
                p0_req_ready = grant[0] & ~rst;
                p1_req_ready = grant[1] & ~rst;
                accept       = (|grant) & ~rst;
                if (accept)
                    state_nxt = ACCESS;
            end
            ACCESS:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // ram_we is cleared every cycle so a latched write drives the RAM for one cycle only.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ram_we    <= 1'b0;
            ram_addr  <= '0;
            ram_wdata <= '0;
            acc_port  <= 1'b0;
            resp_vld  <= 1'b0;
            resp_port <= 1'b0;
            resp_data <= '0;
        end else begin
            state    <= state_nxt;
            ram_we   <= 1'b0;
            resp_vld <= 1'b0;
            if (accept) begin
                ram_we    <= grant[1] ? p1_req_we    : p0_req_we;
                ram_addr  <= grant[1] ? p1_req_addr  : p0_req_addr;
                ram_wdata <= grant[1] ? p1_req_wdata : p0_req_wdata;
                acc_port  <= arb_port_t'(grant[1]);
            end
            if (state == ACCESS) begin
                resp_vld  <= 1'b1;
                resp_port <= acc_port;
                resp_data <= ram_we ? '0 : ram_rdata;
            end
        end
    end

    assign p0_resp_valid = resp_vld & (resp_port == 1'b0);
    assign p1_resp_valid = resp_vld & (resp_port == 1'b1);
    assign p0_resp_rdata = p0_resp_valid ? resp_data : '0;
    assign p1_resp_rdata = p1_resp_valid ? resp_data : '0;

endmodule

// File: tb/tb_dist_ram_arbiter.sv
// Directed bench for dist_ram_arbiter with a real dist_ram behind it.
module tb_dist_ram_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_req_valid = 1'b0, p0_req_ready, p0_req_we = 1'b0;
    logic [AW-1:0] p0_req_addr = '0;
    logic [DW-1:0] p0_req_wdata = '0;
    logic          p0_resp_valid;
    logic [DW-1:0] p0_resp_rdata;
    logic          p1_req_valid = 1'b0, p1_req_ready, p1_req_we = 1'b0;
    logic [AW-1:0] p1_req_addr = '0;
    logic [DW-1:0] p1_req_wdata = '0;
    logic          p1_resp_valid;
    logic [DW-1:0] p1_resp_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_rdata;

    always #5 clk = ~clk;

    dist_ram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst),
        .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready), .p0_req_we(p0_req_we),
        .p0_req_addr(p0_req_addr), .p0_req_wdata(p0_req_wdata),
        .p0_resp_valid(p0_resp_valid), .p0_resp_rdata(p0_resp_rdata),
        .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready), .p1_req_we(p1_req_we),
        .p1_req_addr(p1_req_addr), .p1_req_wdata(p1_req_wdata),
        .p1_resp_valid(p1_resp_valid), .p1_resp_rdata(p1_resp_rdata),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    dist_ram #(.ADDR_W(AW), .DATA_W(DW)) u_ram (
        .clk(clk), .write_enable(ram_we), .addr(ram_addr),
        .data_write(ram_wdata), .data_out(ram_rdata)
    );

    typedef struct {
        logic          port;
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp;
    } vec_t;

    vec_t vecs[10];
    int   checks = 0;
    int   errors = 0;
    logic g_q[$];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk(name, {31'd0, act}, {31'd0, exp});
    endtask

    task automatic drive(input logic port, input logic v, input logic we,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (port) begin
            p1_req_valid = v; p1_req_we = we; p1_req_addr = a; p1_req_wdata = d;
        end else begin
            p0_req_valid = v; p0_req_we = we; p0_req_addr = a; p0_req_wdata = d;
        end
    endtask

    function automatic logic rdy(input logic port);
        return port ? p1_req_ready : p0_req_ready;
    endfunction

    function automatic logic rvld(input logic port);
        return port ? p1_resp_valid : p0_resp_valid;
    endfunction

    function automatic logic [DW-1:0] rdat(input logic port);
        return port ? p1_resp_rdata : p0_resp_rdata;
    endfunction

    // Entered away from posedge; accept at the next edge, response two cycles later.
    task automatic do_req(input vec_t v);
        int n = 0;
        drive(v.port, 1'b1, v.we, v.addr, v.wdata);
        #1;
        while (!rdy(v.port) && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk1("req_ready", rdy(v.port), 1'b1);
        @(posedge clk);
        #1;
        drive(v.port, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk1("access_we", ram_we, v.we);
        chk("access_addr", {22'd0, ram_addr}, {22'd0, v.addr});
        if (v.we) chk("access_wdata", ram_wdata, v.wdata);
        chk1("early_resp", rvld(v.port), 1'b0);
        @(negedge clk);
        chk1("resp_valid", rvld(v.port), 1'b1);
        chk1("other_resp", rvld(~v.port), 1'b0);
        chk("resp_rdata", rdat(v.port), v.exp);
        chk1("we_one_cycle", ram_we, 1'b0);
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        vecs[0] = '{1'b0, 1'b1, 10'd55,   32'd23,         32'd0};
        vecs[1] = '{1'b0, 1'b1, 10'd47,   32'd11,         32'd0};
        vecs[2] = '{1'b0, 1'b1, 10'd147,  32'd1256,       32'd0};
        vecs[3] = '{1'b0, 1'b0, 10'd55,   32'd0,          32'd23};
        vecs[4] = '{1'b0, 1'b0, 10'd47,   32'd0,          32'd11};
        vecs[5] = '{1'b0, 1'b0, 10'd147,  32'd0,          32'd1256};
        vecs[6] = '{1'b1, 1'b1, 10'd1023, 32'hDEADBEEF,   32'd0};
        vecs[7] = '{1'b1, 1'b1, 10'd0,    32'h12345678,   32'd0};
        vecs[8] = '{1'b1, 1'b0, 10'd1023, 32'd0,          32'hDEADBEEF};
        vecs[9] = '{1'b1, 1'b0, 10'd0,    32'd0,          32'h12345678};

        // Reset held two cycles with both requesters asking.
        drive(1'b0, 1'b1, 1'b0, 10'd5, '0);
        drive(1'b1, 1'b1, 1'b1, 10'd6, 32'd9);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk1("rst_p0_ready", p0_req_ready, 1'b0);
            chk1("rst_p1_ready", p1_req_ready, 1'b0);
            chk1("rst_ram_we", ram_we, 1'b0);
            chk("rst_ram_addr", {22'd0, ram_addr}, 32'd0);
            chk1("rst_p0_resp", p0_resp_valid, 1'b0);
            chk1("rst_p1_resp", p1_resp_valid, 1'b0);
            chk("rst_p0_rdata", p0_resp_rdata, 32'd0);
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) do_req(vecs[i]);

        // Simultaneous: p0 reads 55, p1 writes 99 to 55.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 10'd55, '0);
        drive(1'b1, 1'b1, 1'b1, 10'd55, 32'd99);
        #1;
        chk1("sim_p0_ready", p0_req_ready, 1'b1);
        chk1("sim_p1_ready", p1_req_ready, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk1("sim_access_p1_ready", p1_req_ready, 1'b0);
        chk1("sim_access_we", ram_we, 1'b0);
        @(negedge clk);
        chk1("sim_p0_resp", p0_resp_valid, 1'b1);
        chk("sim_p0_rdata", p0_resp_rdata, 32'd23);
        chk1("sim_p1_ready_n2", p1_req_ready, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        @(negedge clk);
        chk1("sim_p1_we", ram_we, 1'b1);
        chk("sim_p1_wdata", ram_wdata, 32'd99);
        @(negedge clk);
        chk1("sim_p1_resp", p1_resp_valid, 1'b1);
        chk("sim_p1_rdata", p1_resp_rdata, 32'd0);
        do_req('{1'b0, 1'b0, 10'd55, 32'd0, 32'd99});

        // Continuous contention: record the winner of each grant.
        do_reset();
        drive(1'b0, 1'b1, 1'b0, 10'd47, '0);
        drive(1'b1, 1'b1, 1'b0, 10'd47, '0);
        #1;
        for (int c = 0; c < 16; c++) begin
            if (p0_req_ready || p1_req_ready) begin
                chk1("one_ready", p0_req_ready ^ p1_req_ready, 1'b1);
                g_q.push_back(p1_req_ready);
            end
            @(negedge clk);
        end
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 8; i++) begin
`ifdef DIST_RAM_ARB_RR_EN
            chk1($sformatf("grant%0d", i), (i < g_q.size()) ? g_q[i] : 1'bx, i[0]);
`else
            chk1($sformatf("grant%0d", i), (i < g_q.size()) ? g_q[i] : 1'bx, 1'b0);
`endif
        end
        repeat (2) @(negedge clk);

        // Reset during the ACCESS of a p1 read.
        drive(1'b1, 1'b1, 1'b0, 10'd147, '0);
        #1;
        chk1("mid_p1_ready", p1_req_ready, 1'b1);
        @(posedge clk);
        #1;
        drive(1'b1, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_access_addr", {22'd0, ram_addr}, 32'd147);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("mid_no_resp", p1_resp_valid, 1'b0);
        chk1("mid_we", ram_we, 1'b0);
        @(negedge clk);
        chk1("mid_no_resp_late", p1_resp_valid, 1'b0);
        do_req('{1'b1, 1'b0, 10'd147, 32'd0, 32'd1256});

        // Reset during a write ACCESS: write lands, no response.
        drive(1'b0, 1'b1, 1'b1, 10'd500, 32'd77);
        #1;
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 1'b0, '0, '0);
        rst = 1'b1;
        @(negedge clk);
        chk1("midw_we", ram_we, 1'b1);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk1("midw_no_resp", p0_resp_valid, 1'b0);
        chk1("midw_we_cleared", ram_we, 1'b0);
        do_req('{1'b0, 1'b0, 10'd500, 32'd0, 32'd77});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
